// File: rtl/spio_hss_multiplexer_pkt_store_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spio_hss_multiplexer_pkt_store_p                                         |
// | Packet store for the HSS frame assembler: holds packets until acked and  |
// | replays from a nak'd sequence number. Optional SPIO_PKT_STORE_STATS_EN   |
// | adds a saturating nak counter.                                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spio_hss_multiplexer_pkt_store_p #(
  parameter int PKT_BITS = 72,
  parameter int SEQ_BITS = 7,
  parameter int BUF_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                force_full,
  input  logic                cfc_rem,
  input  logic [BUF_BITS-1:0] afull_thresh,
  input  logic                vld_ack,
  input  logic                vld_nak,
  input  logic [SEQ_BITS-1:0] ack_seq,
  input  logic [PKT_BITS-1:0] pkt_data,
  input  logic                pkt_vld,
  output logic                pkt_rdy,
  input  logic [SEQ_BITS-1:0] bpkt_seq,
  input  logic                bpkt_rq,
  output logic [PKT_BITS-1:0] bpkt_data,
  output logic                bpkt_pres,
  output logic                bpkt_gt,
  output logic                empty,
  output logic                full,
  output logic                afull,
  output logic [BUF_BITS-1:0] occupancy,
  output logic [BUF_BITS-1:0] unread_cnt
`ifdef SPIO_PKT_STORE_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         nak_cnt
`endif
);

  localparam int c_DEPTH = 2**BUF_BITS;

  logic [PKT_BITS-1:0] r_dbuf    [c_DEPTH];
  logic [BUF_BITS-1:0] r_seq_map [c_DEPTH];

  logic [BUF_BITS-1:0] r_ba, r_br, r_bo, r_bw;
  logic                r_unread, r_full, r_rdy, r_afull, r_pres, r_gt;
  logic [BUF_BITS-1:0] r_occ, r_unrd_cnt;

  logic                w_writing, w_reading;
  logic [BUF_BITS-1:0] w_map_ack;
  logic [BUF_BITS-1:0] w_nxt_bw, w_nxt_br, w_nxt_ba, w_bw_p1;
  logic [BUF_BITS-1:0] w_nxt_occ, w_nxt_unrd;

  assign w_map_ack = r_seq_map[ack_seq[BUF_BITS-1:0]];

  always_comb begin
    w_writing = pkt_vld & ~r_full;
    w_reading = bpkt_rq & r_unread & cfc_rem;
    w_nxt_bw  = r_bw + BUF_BITS'(w_writing);

    w_nxt_br = r_br;
    if (vld_nak)        w_nxt_br = w_map_ack;
    else if (w_reading) w_nxt_br = r_br + BUF_BITS'(1);

    // A nak also acknowledges everything before the replay point.
    w_nxt_ba = r_ba;
    if (vld_nak)                   w_nxt_ba = w_map_ack;
    else if (vld_ack) w_nxt_ba = (ack_seq == bpkt_seq) ? r_br : w_map_ack;

    w_bw_p1    = w_nxt_bw + BUF_BITS'(1);
    w_nxt_occ  = w_nxt_bw - w_nxt_ba;
    w_nxt_unrd = w_nxt_bw - w_nxt_br;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ba       <= '0;
      r_br       <= '0;
      r_bo       <= '0;
      r_bw       <= '0;
      r_unread   <= 1'b0;
      r_full     <= 1'b0;
      r_rdy      <= 1'b0;
      r_afull    <= 1'b0;
      r_pres     <= 1'b0;
      r_gt       <= 1'b0;
      r_occ      <= '0;
      r_unrd_cnt <= '0;
    end else begin
      r_ba       <= w_nxt_ba;
      r_br       <= w_nxt_br;
      r_bw       <= w_nxt_bw;
      r_unread   <= (w_nxt_br != w_nxt_bw);
      r_full     <= (w_nxt_ba == w_bw_p1) | force_full;
      r_rdy      <= ~((w_nxt_ba == w_bw_p1) | force_full);
      r_afull    <= (w_nxt_occ >= afull_thresh) | force_full;
      r_occ      <= w_nxt_occ;
      r_unrd_cnt <= w_nxt_unrd;
      r_gt       <= w_reading;
      if (w_reading) r_bo   <= r_br;
      if (bpkt_rq)   r_pres <= w_reading;
    end
  end

  // Storage arrays are deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_writing) r_dbuf[r_bw] <= pkt_data;
    if (bpkt_rq)   r_seq_map[bpkt_seq[BUF_BITS-1:0]] <= r_br;
  end

  assign bpkt_data  = r_dbuf[r_bo];
  assign bpkt_pres  = r_pres;
  assign bpkt_gt    = r_gt;
  assign empty      = ~r_unread;
  assign full       = r_full;
  assign pkt_rdy    = r_rdy;
  assign afull      = r_afull;
  assign occupancy  = r_occ;
  assign unread_cnt = r_unrd_cnt;

`ifdef SPIO_PKT_STORE_STATS_EN
  logic [15:0] r_nak_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_nak_cnt <= '0;
    else if (stats_clr)                         r_nak_cnt <= '0;
    else if (vld_nak && (r_nak_cnt != 16'hFFFF)) r_nak_cnt <= r_nak_cnt + 16'd1;
  end

  assign nak_cnt = r_nak_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_pkt_store_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spio_hss_multiplexer_pkt_store_p                                      |
// | Directed and randomized bench with a queue-based scoreboard.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spio_hss_multiplexer_pkt_store_p;
  localparam int PB = 72;
  localparam int SB = 7;
  localparam int BB = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          force_full, cfc_rem, vld_ack, vld_nak, pkt_vld, bpkt_rq;
  logic [BB-1:0] afull_thresh;
  logic [SB-1:0] ack_seq, bpkt_seq;
  logic [PB-1:0] pkt_data, bpkt_data;
  logic          pkt_rdy, bpkt_pres, bpkt_gt, empty, full, afull;
  logic [BB-1:0] occupancy, unread_cnt;
`ifdef SPIO_PKT_STORE_STATS_EN
  logic          stats_clr;
  logic [15:0]   nak_cnt;
`endif

  spio_hss_multiplexer_pkt_store_p #(.PKT_BITS(PB), .SEQ_BITS(SB), .BUF_BITS(BB)) dut (
    .clk(clk), .rst(rst), .force_full(force_full), .cfc_rem(cfc_rem),
    .afull_thresh(afull_thresh), .vld_ack(vld_ack), .vld_nak(vld_nak),
    .ack_seq(ack_seq), .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
    .bpkt_seq(bpkt_seq), .bpkt_rq(bpkt_rq), .bpkt_data(bpkt_data),
    .bpkt_pres(bpkt_pres), .bpkt_gt(bpkt_gt), .empty(empty), .full(full),
    .afull(afull), .occupancy(occupancy), .unread_cnt(unread_cnt)
`ifdef SPIO_PKT_STORE_STATS_EN
    , .stats_clr(stats_clr), .nak_cnt(nak_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: absolute (never-wrapping) positions of write, read and ack.
  int            m_w, m_r, m_a, m_nak;
  logic          m_full, m_unread, m_afull, m_rdy, m_pres, m_gt;
  logic [PB-1:0] m_data [int];
  int            m_seqpos [int];
  logic [PB-1:0] exp_q [$];
  logic [SB-1:0] lst_seq [$];
  logic [SB-1:0] cur_seq;

  task automatic chk(input string nm, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_a = 0; m_nak = 0;
    m_full = 0; m_unread = 0; m_afull = 0; m_rdy = 0; m_pres = 0; m_gt = 0;
    m_data.delete(); m_seqpos.delete(); exp_q.delete(); lst_seq.delete();
    cur_seq = '0;
  endtask

  task automatic set_idle();
    pkt_vld = 0; bpkt_rq = 0; vld_ack = 0; vld_nak = 0; cfc_rem = 1;
    ack_seq = '0; bpkt_seq = cur_seq;
`ifdef SPIO_PKT_STORE_STATS_EN
    stats_clr = 0;
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic step();
    bit wr, rd;
    int nr, na;
    wr = pkt_vld && !m_full;
    rd = bpkt_rq && m_unread && cfc_rem;
    if (wr) m_data[m_w] = pkt_data;
    if (rd) exp_q.push_back(m_data[m_r]);
    nr = m_r;
    na = m_a;
    if (vld_nak) begin
      nr = m_seqpos[int'(ack_seq)];
      na = nr;
    end else begin
      if (rd) nr = m_r + 1;
      if (vld_ack) na = (ack_seq == bpkt_seq) ? m_r : m_seqpos[int'(ack_seq)];
    end
    if (bpkt_rq) m_seqpos[int'(bpkt_seq)] = m_r;
`ifdef SPIO_PKT_STORE_STATS_EN
    if (stats_clr) m_nak = 0;
    else if (vld_nak && m_nak < 65535) m_nak++;
`endif
    m_w = m_w + (wr ? 1 : 0);
    m_r = nr;
    m_a = na;
    m_full   = ((m_w - m_a) == DEPTH - 1) || force_full;
    m_rdy    = !m_full;
    m_unread = (m_r != m_w);
    m_afull  = ((m_w - m_a) >= int'(afull_thresh)) || force_full;
    m_gt     = rd;
    if (bpkt_rq) m_pres = rd;
  endtask

  task automatic check_flags();
    logic [BB-1:0] e_occ, e_unrd;
    e_occ  = BB'(m_w - m_a);
    e_unrd = BB'(m_w - m_r);
    chk("full", PB'(full), PB'(m_full));
    chk("pkt_rdy", PB'(pkt_rdy), PB'(m_rdy));
    chk("empty", PB'(empty), PB'(!m_unread));
    chk("afull", PB'(afull), PB'(m_afull));
    chk("occupancy", PB'(occupancy), PB'(e_occ));
    chk("unread_cnt", PB'(unread_cnt), PB'(e_unrd));
    chk("bpkt_gt", PB'(bpkt_gt), PB'(m_gt));
    chk("bpkt_pres", PB'(bpkt_pres), PB'(m_pres));
`ifdef SPIO_PKT_STORE_STATS_EN
    chk("nak_cnt", PB'(nak_cnt), PB'(m_nak));
`endif
  endtask

  task automatic tick();
    step();
    @(posedge clk);
    #1;
    check_flags();
  endtask

  task automatic do_reset();
    set_idle();
    rst = 0;
    model_reset();
    bpkt_seq = cur_seq;
    @(negedge clk);
    chk("rst_pkt_rdy", PB'(pkt_rdy), PB'(0));
    chk("rst_full", PB'(full), PB'(0));
    chk("rst_afull", PB'(afull), PB'(0));
    chk("rst_pres", PB'(bpkt_pres), PB'(0));
    chk("rst_gt", PB'(bpkt_gt), PB'(0));
    chk("rst_empty", PB'(empty), PB'(1));
    chk("rst_occ", PB'(occupancy), PB'(0));
    chk("rst_unread_cnt", PB'(unread_cnt), PB'(0));
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic wr_pkt();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    pkt_data = t[PB-1:0];
  endtask

  // Scoreboard monitor: every grant must match the oldest predicted packet.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bpkt_gt === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL grant_unexpected: got grant, required none at %0t", $time);
        end else begin
          chk("bpkt_data", bpkt_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic rand_cycle();
    int n, idx;
    set_idle();
    pkt_vld    = ($urandom_range(99) < 60);
    wr_pkt();
    bpkt_rq    = ($urandom_range(99) < 50);
    cfc_rem    = ($urandom_range(9) != 0);
    force_full = ($urandom_range(19) == 0);
    n = lst_seq.size();
    if (n > 0 && $urandom_range(99) < 6) begin
      vld_nak = 1;
      ack_seq = lst_seq[$urandom_range(n - 1)];
      vld_ack = ($urandom_range(1) == 1);
    end else if ($urandom_range(99) < 25) begin
      vld_ack = 1;
      if (n > 0 && $urandom_range(1) == 1) ack_seq = lst_seq[$urandom_range(n - 1)];
      else ack_seq = cur_seq;
    end
    tick();
    // Frame-side protocol bookkeeping: which sequence numbers may be acked/nak'd.
    if (bpkt_rq) begin
      lst_seq.push_back(cur_seq);
      cur_seq = cur_seq + 1'b1;
    end
    if (vld_nak) begin
      idx = 0;
      while (idx < lst_seq.size() && lst_seq[idx] != ack_seq) idx++;
      while (lst_seq.size() > idx) void'(lst_seq.pop_back());
      cur_seq = ack_seq;
    end
    while (lst_seq.size() > DEPTH - 1) void'(lst_seq.pop_front());
    while (lst_seq.size() > 0 && m_seqpos[int'(lst_seq[0])] < m_a) void'(lst_seq.pop_front());
  endtask

  initial begin
    rst = 1; force_full = 0; afull_thresh = 3'd7; pkt_data = '0;
    model_reset();
    set_idle();
    #2;
    do_reset();

    // Fill to capacity; the eighth packet must be refused.
    for (int i = 0; i < 7; i++) begin set_idle(); pkt_vld = 1; wr_pkt(); tick(); end
    chk("fill_full", PB'(full), PB'(1));
    chk("fill_rdy", PB'(pkt_rdy), PB'(0));
    chk("fill_occ", PB'(occupancy), PB'(7));
    set_idle(); pkt_vld = 1; wr_pkt(); tick();
    chk("fill_8th_occ", PB'(occupancy), PB'(7));

    // Write A,B,C then send seq 0..2, nak seq 1, replay, then ack at the issue point.
    do_reset();
    for (int i = 0; i < 3; i++) begin set_idle(); pkt_vld = 1; wr_pkt(); tick(); end
    for (int i = 0; i < 3; i++) begin set_idle(); bpkt_rq = 1; bpkt_seq = SB'(i); tick(); end
    set_idle(); tick();
    chk("abc_empty", PB'(empty), PB'(1));
    chk("abc_unread_cnt", PB'(unread_cnt), PB'(0));
    set_idle(); vld_nak = 1; ack_seq = 7'd1; tick();
    chk("nak_occ", PB'(occupancy), PB'(2));
    chk("nak_unread", PB'(empty), PB'(0));
    for (int i = 1; i < 3; i++) begin set_idle(); bpkt_rq = 1; bpkt_seq = SB'(i); tick(); end
    set_idle(); vld_ack = 1; ack_seq = 7'd3; bpkt_seq = 7'd3; tick();
    chk("ack_occ", PB'(occupancy), PB'(0));
    chk("ack_full", PB'(full), PB'(0));
    chk("ack_rdy", PB'(pkt_rdy), PB'(1));

    // Almost-full threshold and forced-full with reads continuing.
    do_reset();
    afull_thresh = 3'd4;
    for (int i = 0; i < 4; i++) begin set_idle(); pkt_vld = 1; wr_pkt(); tick(); end
    chk("afull_set", PB'(afull), PB'(1));
    set_idle(); bpkt_rq = 1; bpkt_seq = 7'd0; tick();
    set_idle(); vld_ack = 1; ack_seq = 7'd1; bpkt_seq = 7'd1; tick();
    chk("afull_clr", PB'(afull), PB'(0));
    set_idle(); force_full = 1; bpkt_rq = 1; bpkt_seq = 7'd1; tick();
    chk("ff_full", PB'(full), PB'(1));
    chk("ff_rdy", PB'(pkt_rdy), PB'(0));
    chk("ff_gt", PB'(bpkt_gt), PB'(1));
    force_full = 0;
    set_idle(); tick();

    // Pointer wrap with continual acks at the issue point.
    do_reset();
    afull_thresh = 3'd7;
    for (int i = 0; i < 20; i++) begin
      set_idle(); pkt_vld = 1; wr_pkt(); bpkt_rq = 1; bpkt_seq = SB'(i);
      vld_ack = (i > 0); ack_seq = SB'(i);
      tick();
      chk("wrap_no_full", PB'(full), PB'(0));
    end
    for (int i = 20; i < 23; i++) begin set_idle(); bpkt_rq = 1; bpkt_seq = SB'(i); tick(); end

`ifdef SPIO_PKT_STORE_STATS_EN
    do_reset();
    set_idle(); pkt_vld = 1; wr_pkt(); tick();
    set_idle(); bpkt_rq = 1; bpkt_seq = 7'd0; tick();
    for (int i = 0; i < 3; i++) begin set_idle(); vld_nak = 1; ack_seq = 7'd0; bpkt_seq = 7'd1; tick(); end
    chk("stats_nak3", PB'(nak_cnt), PB'(3));
    set_idle(); stats_clr = 1; tick();
    chk("stats_clr", PB'(nak_cnt), PB'(0));
`endif

    // Randomized traffic, with a reset landing in the middle of it.
    for (int seg = 0; seg < 2; seg++) begin
      do_reset();
      afull_thresh = BB'($urandom_range(7));
      for (int i = 0; i < 1500; i++) rand_cycle();
    end
    force_full = 0;
    for (int i = 0; i < 4; i++) begin set_idle(); tick(); end
    chk("scoreboard_drained", PB'(exp_q.size()), PB'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
